// File: rtl/nearest_upsample_2x.sv
// -----------------------------------------------------------------------------
// nearest_upsample_2x
//   Expands a raster-scan feature map of IN_WIDTH x IN_HEIGHT signed pixels to
//   2*IN_WIDTH x 2*IN_HEIGHT by nearest-neighbour replication: every input
//   pixel becomes a 2x2 block of identical output pixels.
//
//   Each input row is handled in two passes:
//     FILL   - emits output row 2*ry while accepting the input row. Every
//              accepted pixel is emitted twice and also saved in a one-row
//              line buffer.
//     REPLAY - emits output row 2*ry+1 from the line buffer. No input is
//              accepted in this pass.
//
//   Ports
//     clk           in   rising-edge clock
//     rst_n         in   asynchronous active-low reset
//     start_signal  in   begin a frame (only looked at while idle)
//     pixel_valid   in   pixel_in valid; a transfer needs pixel_valid && pixel_ready
//     pixel_in      in   signed input pixel, raster order
//     pixel_ready   out  block accepts pixel_in this cycle (decoded from state)
//     result_out    out  signed upsampled pixel, raster order (registered)
//     result_valid  out  result_out valid this cycle (registered)
//     done_signal   out  one-cycle frame-complete pulse (decoded from state)
// -----------------------------------------------------------------------------
module nearest_upsample_2x #(
   parameter int IN_WIDTH  = 16,
   parameter int IN_HEIGHT = 16,
   parameter int DATA_W    = 22
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_signal,
   input  logic                     pixel_valid,
   input  logic signed [DATA_W-1:0] pixel_in,
   output logic                     pixel_ready,
   output logic signed [DATA_W-1:0] result_out,
   output logic                     result_valid,
   output logic                     done_signal
);

   localparam int CX_W = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
   localparam int RY_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

   localparam logic [CX_W-1:0] CX_LAST = CX_W'(IN_WIDTH - 1);
   localparam logic [RY_W-1:0] RY_LAST = RY_W'(IN_HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_REPLAY = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                     state_r;
   logic [CX_W-1:0]            cx_r;
   logic [RY_W-1:0]            ry_r;
   logic                       ph_r;       // 0: first copy of a pixel, 1: second copy
   logic signed [DATA_W-1:0]   line_buf_r [IN_WIDTH];
   logic signed [DATA_W-1:0]   result_out_r;
   logic                       result_valid_r;

   logic                       pixel_ready_s;
   logic                       done_s;
   logic                       transfer_s;

   // Handshake and completion flags decoded directly from the current state
   always_comb begin
      pixel_ready_s = 1'b0;
      done_s        = 1'b0;
      case (state_r)
         ST_FILL: begin
            // Input is only taken on the first copy of each pixel
            pixel_ready_s = ~ph_r;
         end
         ST_DONE: begin
            done_s = 1'b1;
         end
         default: begin
            pixel_ready_s = 1'b0;
            done_s        = 1'b0;
         end
      endcase
   end

   assign transfer_s = pixel_valid & pixel_ready_s;

   // Frame sequencer: counters, line buffer and registered output stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         cx_r           <= '0;
         ry_r           <= '0;
         ph_r           <= 1'b0;
         result_out_r   <= '0;
         result_valid_r <= 1'b0;
         for (int i = 0; i < IN_WIDTH; i++) begin
            line_buf_r[i] <= '0;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               result_valid_r <= 1'b0;
               if (start_signal) begin
                  state_r <= ST_FILL;
                  cx_r    <= '0;
                  ry_r    <= '0;
                  ph_r    <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end

            ST_FILL: begin
               if (!ph_r) begin
                  if (transfer_s) begin
                     line_buf_r[cx_r] <= pixel_in;
                     result_out_r     <= pixel_in;
                     result_valid_r   <= 1'b1;
                     ph_r             <= 1'b1;
                  end else begin
                     // Source stalled: bubble, result_out keeps its value
                     result_valid_r <= 1'b0;
                  end
               end else begin
                  // Second copy: result_out already holds the pixel
                  result_valid_r <= 1'b1;
                  ph_r           <= 1'b0;
                  if (cx_r == CX_LAST) begin
                     cx_r    <= '0;
                     state_r <= ST_REPLAY;
                  end else begin
                     cx_r <= cx_r + CX_W'(1);
                  end
               end
            end

            ST_REPLAY: begin
               result_out_r   <= line_buf_r[cx_r];
               result_valid_r <= 1'b1;
               if (!ph_r) begin
                  ph_r <= 1'b1;
               end else begin
                  ph_r <= 1'b0;
                  if (cx_r == CX_LAST) begin
                     cx_r <= '0;
                     if (ry_r == RY_LAST) begin
                        state_r <= ST_DONE;
                     end else begin
                        ry_r    <= ry_r + RY_W'(1);
                        state_r <= ST_FILL;
                     end
                  end else begin
                     cx_r <= cx_r + CX_W'(1);
                  end
               end
            end

            ST_DONE: begin
               // The last replayed pixel is still valid during this cycle
               result_valid_r <= 1'b0;
               state_r        <= ST_IDLE;
            end

            default: begin
               result_valid_r <= 1'b0;
               state_r        <= ST_IDLE;
            end
         endcase
      end
   end

   assign pixel_ready  = pixel_ready_s;
   assign done_signal  = done_s;
   assign result_out   = result_out_r;
   assign result_valid = result_valid_r;

endmodule

// File: tb/tb_nearest_upsample_2x.sv
module tb_nearest_upsample_2x;

   localparam int W     = 16;
   localparam int H     = 16;
   localparam int D     = 22;
   localparam int FRAME = 4 * W * H;
   localparam int ROW2  = 2 * W;

   logic                clk;
   logic                rst_n;
   logic                start_signal;
   logic                pixel_valid;
   logic signed [D-1:0] pixel_in;
   logic                pixel_ready;
   logic signed [D-1:0] result_out;
   logic                result_valid;
   logic                done_signal;

   int tests_run = 0;
   int tests_failed = 0;

   logic signed [D-1:0] sb_q [$];
   logic signed [D-1:0] pix [W*H];
   int  out_idx = 0;
   bit  prev_valid = 1'b0;
   bit  prev_done = 1'b0;

   nearest_upsample_2x #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_W(D)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_signal (start_signal),
      .pixel_valid  (pixel_valid),
      .pixel_in     (pixel_in),
      .pixel_ready  (pixel_ready),
      .result_out   (result_out),
      .result_valid (result_valid),
      .done_signal  (done_signal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every valid output, checks frame framing
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (result_valid === 1'b1) begin
               if (sb_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("FAIL unexpected_output: got %0d, expected no output", result_out);
               end else begin
                  chk($sformatf("pixel[%0d]", out_idx), result_out, sb_q.pop_front());
               end
               // Replay (odd) rows must be back-to-back
               if (((out_idx / ROW2) % 2 == 1) && (out_idx % ROW2 != 0))
                  chk("replay_contiguous", prev_valid, 1);
               out_idx++;
            end
            if (done_signal === 1'b1) begin
               chk("done_single_pulse", prev_done, 0);
               chk("done_with_last_valid", result_valid, 1);
               chk("frame_output_count", out_idx, FRAME);
               out_idx = 0;
            end
            prev_valid = (result_valid === 1'b1);
            prev_done  = (done_signal === 1'b1);
         end
      end
   end

   task automatic push_replicated();
      for (int y = 0; y < 2*H; y++)
         for (int x = 0; x < 2*W; x++)
            sb_q.push_back(pix[(y/2)*W + x/2]);
   endtask

   // Handshaking source; stops after n_drive pixels, optional start pulse at cycle pulse_at
   task automatic drive_frame(input int n_drive, input bit gaps, input int pulse_at);
      int idx = 0;
      int cyc = 0;
      @(negedge clk);
      start_signal = 1'b1;
      @(negedge clk);
      start_signal = 1'b0;
      while (idx < n_drive && cyc < 8*FRAME) begin
         pixel_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         pixel_in     = pix[idx];
         start_signal = (cyc == pulse_at);
         if (pixel_valid && pixel_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      pixel_valid  = 1'b0;
      start_signal = 1'b0;
      chk("drive_complete", idx, n_drive);
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_signal !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done_signal, 1);
      @(negedge clk);
      chk("done_deasserted", done_signal, 0);
      chk("valid_after_done", result_valid, 0);
      chk("scoreboard_empty", sb_q.size(), 0);
   endtask

   task automatic load_ramp();
      for (int i = 0; i < W*H; i++) pix[i] = D'(16*(i/W) + (i%W));
   endtask

   task automatic push_ramp_expected();
      for (int y = 0; y < 2*H; y++)
         for (int x = 0; x < 2*W; x++)
            sb_q.push_back(D'(16*(y>>1) + (x>>1)));
   endtask

   initial begin
      rst_n        = 1'b0;
      start_signal = 1'b0;
      pixel_valid  = 1'b0;
      pixel_in     = '0;

      // 1: reset state, then valid input without start is ignored
      repeat (3) @(negedge clk);
      chk("rst_result_out", result_out, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_done", done_signal, 0);
      chk("rst_ready", pixel_ready, 0);
      rst_n       = 1'b1;
      pixel_valid = 1'b1;
      pixel_in    = 22'sd5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_ready", pixel_ready, 0);
         chk("idle_valid", result_valid, 0);
      end
      pixel_valid = 1'b0;

      // 2: full frame, continuous input, ramp 16r+c
      load_ramp();
      push_ramp_expected();
      drive_frame(W*H, 1'b0, -1);
      wait_done();

      // 3: extremes alternating
      for (int i = 0; i < W*H; i++)
         pix[i] = (i % 2 == 1) ? 22'sd2097151 : -22'sd2097152;
      push_replicated();
      drive_frame(W*H, 1'b0, -1);
      wait_done();

      // 4: gapped input
      for (int i = 0; i < W*H; i++) pix[i] = D'(3*i - 700);
      push_replicated();
      drive_frame(W*H, 1'b1, -1);
      wait_done();

      // 5: pixel_in changes every cycle; only values seen while ready=1 are taken
      for (int r = 0; r < H; r++)
         for (int rep = 0; rep < 2; rep++)
            for (int x = 0; x < 2*W; x++)
               sb_q.push_back(D'(-500 + r*4*W + 2*(x/2)));
      @(negedge clk);
      start_signal = 1'b1;
      @(negedge clk);
      start_signal = 1'b0;
      for (int t = 0; t < FRAME; t++) begin
         pixel_valid = 1'b1;
         pixel_in    = D'(-500 + t);
         chk("ready_pattern", pixel_ready, ((t % (4*W)) < 2*W && (t % 2) == 0) ? 1 : 0);
         @(negedge clk);
      end
      pixel_valid = 1'b0;
      wait_done();

      // 6a: start pulsed mid-frame is ignored
      load_ramp();
      push_ramp_expected();
      drive_frame(W*H, 1'b0, 50);
      wait_done();

      // 6b: async reset mid-frame, then a clean frame
      push_ramp_expected();
      drive_frame(40, 1'b0, -1);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_result_out", result_out, 0);
      chk("midrst_result_valid", result_valid, 0);
      chk("midrst_ready", pixel_ready, 0);
      chk("midrst_done", done_signal, 0);
      sb_q.delete();
      out_idx    = 0;
      prev_valid = 1'b0;
      prev_done  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      push_ramp_expected();
      drive_frame(W*H, 1'b0, -1);
      wait_done();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
